// File: rtl/div_pkg.sv
// Shared definitions for the switch/button divider and its sibling multiplier.
//   div_state_e      : controller state encoding (IDLE / CALC / DONE; 2'b11 unused)
//   DIV_ZERO_PATTERN : LED pattern shown after a divide by zero (all ones);
//                      wide enough for any WIDTH up to MAX_WIDTH, users slice it.
package div_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam logic [2*MAX_WIDTH-1:0] DIV_ZERO_PATTERN = '1;

endpackage

// File: rtl/button_edge_sync.sv
// Push-button front end: two-flop synchronizer followed by a one-flop edge
// register, producing a single-cycle pulse per press.
//   clock    : system clock
//   reset_n  : asynchronous active-low reset (all flops cleared)
//   btn_in   : raw asynchronous button, active-high
//   btn_rise : one-cycle pulse on each synchronized rising edge
module button_edge_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_in,
  output logic btn_rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // A held button leaves sync2 and prev both high, so no retrigger.
  assign btn_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/button_divider.sv
// Board-level restoring divider. A centre-button press captures
// dividend/divisor from the switches, resolves one quotient bit per clock,
// and shows {quotient, remainder} on the LEDs until the next press clears them.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   sw      : sw[2W-1:W] = dividend, sw[W-1:0] = divisor (unsigned)
//   btnC    : raw push button, active-high
//   led     : led[2W-1:W] = quotient, led[W-1:0] = remainder;
//             all ones after a divide by zero, zero while idle/computing
//
// Handshake: there is no valid/ready pair; a start request is the one-cycle
// btn_rise pulse, accepted only in IDLE, and the result is "valid" exactly
// while the controller sits in DONE. Requests in CALC or DONE are not queued.
// The controller state is visible on the internal state_q register.
module button_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [2*WIDTH-1:0] sw,
  input  logic               btnC,
  output logic [2*WIDTH-1:0] led
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic btn_rise;

  button_edge_sync u_btn (
    .clock    (clock),
    .reset_n  (reset_n),
    .btn_in   (btnC),
    .btn_rise (btn_rise)
  );

  div_state_e         state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] led_q, led_d;

  // One restoring step at W+1 bits: the shifted partial remainder can reach
  // 2*divisor-1, which needs the extra bit before the compare.
  logic [WIDTH:0]     r_ext;
  logic [WIDTH:0]     r_sub;
  logic               r_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  always_comb begin
    r_ext    = {rem_q, dvd_q[WIDTH-1]};
    r_sub    = r_ext - {1'b0, dvs_q};
    r_ge     = (r_ext >= {1'b0, dvs_q});
    // When r_ge is low, r_ext < divisor so it fits in WIDTH bits.
    rem_next = r_ge ? r_sub[WIDTH-1:0] : r_ext[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], r_ge};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    led_d   = led_q;

    case (state_q)
      IDLE: begin
        led_d = '0;
        if (btn_rise) begin
          dvd_d = sw[2*WIDTH-1:WIDTH];
          dvs_d = sw[WIDTH-1:0];
          rem_d = '0;
          quo_d = '0;
          cnt_d = '0;
          if (sw[WIDTH-1:0] == '0) begin
            // Skip the iteration entirely; the loop would produce garbage.
            state_d = DONE;
            led_d   = DIV_ZERO_PATTERN[2*WIDTH-1:0];
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          led_d   = {quo_next, rem_next};
          state_d = DONE;
        end
      end

      DONE: begin
        if (btn_rise) begin
          led_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_button_divider.sv
// Bench for button_divider (WIDTH = 8). Inputs are driven on the falling
// edge and outputs sampled on the falling edge. A press driven at a falling
// edge is captured on the third following rising edge (two sync flops plus
// the edge register); the result appears WIDTH edges after that.
module tb_button_divider;
  import div_pkg::*;

  localparam int W = 8;

  logic           clock;
  logic           reset_n;
  logic [2*W-1:0] sw;
  logic           btnC;
  logic [2*W-1:0] led;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W-1:0] exp_q[$];

  button_divider #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .sw      (sw),
    .btnC    (btnC),
    .led     (led)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_div(input logic [2*W-1:0] s);
    int a, b, q, r;
    logic [2*W-1:0] res;
    a = int'(s[2*W-1:W]);
    b = int'(s[W-1:0]);
    if (b == 0) begin
      res = {(2*W){1'b1}};
    end else begin
      q = a / b;
      r = a % b;
      res = {q[W-1:0], r[W-1:0]};
    end
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  // One-cycle press; returns at the falling edge just after the capture edge.
  task automatic press_pulse();
    @(negedge clock);
    btnC = 1'b1;
    @(negedge clock);
    btnC = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Full division with latency check, then a clearing press.
  task automatic do_division(input logic [2*W-1:0] sw_val, input string name);
    logic [2*W-1:0] e;
    sw = sw_val;
    exp_q.push_back(ref_div(sw_val));
    press_pulse();
    repeat (W - 1) @(negedge clock);
    n_checks++;
    if (led !== '0) begin
      n_fail++;
      $display("FAIL %s early: led=%h required=0000", name, led);
    end
    @(negedge clock);
    e = exp_q.pop_front();
    n_checks++;
    if (led !== e) begin
      n_fail++;
      $display("FAIL %s result: sw=%h led=%h required=%h", name, sw_val, led, e);
    end
    press_pulse();
    n_checks++;
    if (led !== '0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL %s clear: led=%h state=%0d required 0000/IDLE", name, led, dut.state_q);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    btnC    = 1'b0;
    sw      = '0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (led !== '0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_held: led=%h state=%0d required 0000/IDLE", led, dut.state_q);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (led !== '0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_release: led=%h state=%0d required 0000/IDLE", led, dut.state_q);
    end
  endtask

  task automatic test_basic();
    logic [2*W-1:0] e;
    sw = 16'hC807;
    e  = ref_div(sw);
    press_pulse();
    repeat (W - 1) @(negedge clock);
    n_checks++;
    if (led !== '0) begin
      n_fail++;
      $display("FAIL basic_early: led=%h required=0000", led);
    end
    @(negedge clock);
    n_checks++;
    if (led !== 16'h1C04 || e !== 16'h1C04) begin
      n_fail++;
      $display("FAIL basic_result: led=%h required=1C04", led);
    end
    repeat (100) @(negedge clock);
    n_checks++;
    if (led !== 16'h1C04 || dut.state_q !== DONE) begin
      n_fail++;
      $display("FAIL basic_hold: led=%h state=%0d required 1C04/DONE", led, dut.state_q);
    end
    press_pulse();
    n_checks++;
    if (led !== '0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL basic_clear: led=%h state=%0d required 0000/IDLE", led, dut.state_q);
    end
  endtask

  task automatic test_small();
    do_division(16'h0509, "small_5_9");
    do_division(16'hFF01, "max_by_1");
    do_division(16'hFFFF, "max_by_max");
  endtask

  task automatic test_div_zero();
    sw = 16'h2500;
    press_pulse();
    n_checks++;
    if (led !== 16'hFFFF || dut.state_q !== DONE) begin
      n_fail++;
      $display("FAIL div_zero: led=%h state=%0d required FFFF/DONE", led, dut.state_q);
    end
    repeat (W + 2) @(negedge clock);
    n_checks++;
    if (led !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL div_zero_hold: led=%h required=FFFF", led);
    end
    press_pulse();
    n_checks++;
    if (led !== '0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL div_zero_clear: led=%h state=%0d required 0000/IDLE", led, dut.state_q);
    end
  endtask

  task automatic test_held();
    logic [2*W-1:0] e;
    sw = 16'hC807;
    e  = ref_div(sw);
    @(negedge clock);
    btnC = 1'b1;
    repeat (3) @(negedge clock);
    repeat (W) @(negedge clock);
    n_checks++;
    if (led !== e) begin
      n_fail++;
      $display("FAIL held_result: led=%h required=%h", led, e);
    end
    repeat (200 - 3 - W) @(negedge clock);
    btnC = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++;
    if (led !== e || dut.state_q !== DONE) begin
      n_fail++;
      $display("FAIL held_no_retrigger: led=%h state=%0d required %h/DONE", led, dut.state_q, e);
    end
    press_pulse();
    n_checks++;
    if (led !== '0) begin
      n_fail++;
      $display("FAIL held_clear: led=%h required=0000", led);
    end
  endtask

  task automatic test_press_in_calc();
    logic [2*W-1:0] e;
    sw = 16'h9B0C;
    e  = ref_div(sw);
    press_pulse();
    repeat (2) @(negedge clock);
    btnC = 1'b1;
    @(negedge clock);
    btnC = 1'b0;
    repeat (W - 3) @(negedge clock);
    n_checks++;
    if (led !== e || dut.state_q !== DONE) begin
      n_fail++;
      $display("FAIL press_in_calc: led=%h state=%0d required %h/DONE", led, dut.state_q, e);
    end
    press_pulse();
  endtask

  task automatic test_sw_change();
    logic [2*W-1:0] e;
    sw = 16'hE70D;
    e  = ref_div(sw);
    press_pulse();
    @(negedge clock);
    sw = 16'h3F05;
    repeat (W - 1) @(negedge clock);
    n_checks++;
    if (led !== e) begin
      n_fail++;
      $display("FAIL sw_change_in_calc: led=%h required=%h", led, e);
    end
    press_pulse();
  endtask

  task automatic test_done_clear();
    do_division(16'h7F06, "done_clear");
    repeat (20) @(negedge clock);
    n_checks++;
    if (led !== '0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL done_no_restart: led=%h state=%0d required 0000/IDLE", led, dut.state_q);
    end
  endtask

  task automatic test_reset_mid();
    sw = 16'hC807;
    press_pulse();
    repeat (3) @(negedge clock);  // inside the 4th CALC cycle
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (led !== '0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_async: led=%h state=%0d required 0000/IDLE", led, dut.state_q);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (led !== '0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_release: led=%h state=%0d required 0000/IDLE", led, dut.state_q);
    end
    do_division(16'h6403, "after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 200; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      do_division({a, b}, "random");
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_small();
    test_div_zero();
    test_held();
    test_press_in_calc();
    test_sw_change();
    test_done_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
